// File: rtl/regset_arbiter_if.sv
// Signal bundle around regset_arbiter: two requester ports, the register-set command/response
// pair and the arbiter status outputs. The slave modport is the arbiter's view.
interface regset_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned WordWidth = 4 * DATA_WIDTH;

  // Requester 0
  logic [1:0]            m0_req;
  logic                  m0_wnr;
  logic [ADDR_WIDTH-1:0] m0_address;
  logic [WordWidth-1:0]  m0_data_in;
  logic                  m0_ack;
  logic                  m0_err;
  logic [WordWidth-1:0]  m0_data_out;

  // Requester 1
  logic [1:0]            m1_req;
  logic                  m1_wnr;
  logic [ADDR_WIDTH-1:0] m1_address;
  logic [WordWidth-1:0]  m1_data_in;
  logic                  m1_ack;
  logic                  m1_err;
  logic [WordWidth-1:0]  m1_data_out;

  // Register-set side
  logic [1:0]            rs_req;
  logic                  rs_wnr;
  logic [ADDR_WIDTH-1:0] rs_address;
  logic [WordWidth-1:0]  rs_data_in;
  logic                  rs_ack;
  logic [WordWidth-1:0]  rs_data_out;

  // Status
  logic                  busy;
  logic                  owner;

  modport slave (
    input  m0_req, m0_wnr, m0_address, m0_data_in,
    output m0_ack, m0_err, m0_data_out,
    input  m1_req, m1_wnr, m1_address, m1_data_in,
    output m1_ack, m1_err, m1_data_out,
    output rs_req, rs_wnr, rs_address, rs_data_in,
    input  rs_ack, rs_data_out,
    output busy, owner
  );

  modport master (
    output m0_req, m0_wnr, m0_address, m0_data_in,
    input  m0_ack, m0_err, m0_data_out,
    output m1_req, m1_wnr, m1_address, m1_data_in,
    input  m1_ack, m1_err, m1_data_out,
    input  rs_req, rs_wnr, rs_address, rs_data_in,
    output rs_ack, rs_data_out,
    input  busy, owner
  );
endinterface

// File: rtl/regset_arbiter.sv
// Two-requester round-robin arbiter in front of a register set: range check at grant, one
// outstanding register-set access with an ack timeout, all outputs registered.
module regset_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic            clk,
  input logic            reset,
  regset_arbiter_if.slave bus
);
  localparam int unsigned WordWidth   = 4 * DATA_WIDTH;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  busy_q, busy_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            rs_req_q, rs_req_d;
  logic                  rs_wnr_q, rs_wnr_d;
  logic [ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d;
  logic [WordWidth-1:0]  rs_wdata_q, rs_wdata_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [WordWidth-1:0]  m0_rdata_q, m0_rdata_d;
  logic [WordWidth-1:0]  m1_rdata_q, m1_rdata_d;

  // Grant selection and range check of the candidate request
  logic                  pend0, pend1, gnt;
  logic [1:0]            sel_req;
  logic                  sel_wnr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WordWidth-1:0]  sel_wdata;
  logic [1:0]            span;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  range_err;

  always_comb begin
    pend0 = (bus.m0_req != 2'd0);
    pend1 = (bus.m1_req != 2'd0);
    // On a tie the requester not served last wins; otherwise whoever is pending.
    gnt   = (pend0 && pend1) ? ~last_grant_q : pend1;
    if (gnt) begin
      sel_req   = bus.m1_req;
      sel_wnr   = bus.m1_wnr;
      sel_addr  = bus.m1_address;
      sel_wdata = bus.m1_data_in;
    end else begin
      sel_req   = bus.m0_req;
      sel_wnr   = bus.m0_wnr;
      sel_addr  = bus.m0_address;
      sel_wdata = bus.m0_data_in;
    end
    case (sel_req)
      2'd2:    span = 2'd1;
      2'd3:    span = 2'd3;
      default: span = 2'd0;
    endcase
    // Carry out of the last byte address means the access wraps past the top.
    end_addr  = {1'b0, sel_addr} + {{(ADDR_WIDTH - 1){1'b0}}, span};
    range_err = end_addr[ADDR_WIDTH];
  end

  logic                 resp_fire, resp_err;
  logic [WordWidth-1:0] resp_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    rs_req_d     = 2'd0;
    rs_wnr_d     = rs_wnr_q;
    rs_addr_d    = rs_addr_q;
    rs_wdata_d   = rs_wdata_q;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (pend0 || pend1) begin
          last_grant_d = gnt;
          owner_d      = gnt;
          if (range_err) begin
            state_d   = StResp;
            resp_fire = 1'b1;
            resp_err  = 1'b1;
          end else begin
            state_d    = StIssue;
            rs_req_d   = sel_req;
            rs_wnr_d   = sel_wnr;
            rs_addr_d  = sel_addr;
            rs_wdata_d = sel_wnr ? sel_wdata : '0;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = 8'd0;
      end
      StWait: begin
        if (bus.rs_ack) begin
          state_d   = StResp;
          resp_fire = 1'b1;
          resp_data = rs_wnr_q ? '0 : bus.rs_data_out;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StResp;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Responses are steered only to the granted requester; everything else stays low.
    ack_d      = resp_fire ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    err_d      = resp_err ? ack_d : 2'b00;
    m0_rdata_d = (resp_fire && !owner_d) ? resp_data : '0;
    m1_rdata_d = (resp_fire && owner_d) ? resp_data : '0;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= 8'd0;
      rs_req_q     <= 2'd0;
      rs_wnr_q     <= 1'b0;
      rs_addr_q    <= '0;
      rs_wdata_q   <= '0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      rs_req_q     <= rs_req_d;
      rs_wnr_q     <= rs_wnr_d;
      rs_addr_q    <= rs_addr_d;
      rs_wdata_q   <= rs_wdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign bus.m0_ack      = ack_q[0];
  assign bus.m0_err      = err_q[0];
  assign bus.m0_data_out = m0_rdata_q;
  assign bus.m1_ack      = ack_q[1];
  assign bus.m1_err      = err_q[1];
  assign bus.m1_data_out = m1_rdata_q;
  assign bus.rs_req      = rs_req_q;
  assign bus.rs_wnr      = rs_wnr_q;
  assign bus.rs_address  = rs_addr_q;
  assign bus.rs_data_in  = rs_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;

endmodule

// File: doc/regset_arbiter.md
REGSET_ARBITER -- requirements
Module: regset_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for rs_ack (range 1..255).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports m0_req / m1_req  in  2  access size per requester: 0 = none, 1 = 1 byte, 2 = 2 bytes, 3 = 4 bytes.
REQ-007 SHALL have ports m0_wnr / m1_wnr  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_address / m1_address  in  ADDR_WIDTH  start register address.
REQ-009 SHALL have ports m0_data_in / m1_data_in  in  4*DATA_WIDTH  write data, byte 0 at the LSBs.
REQ-010 SHALL have ports m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_err / m1_err  out  1  error flag, valid only while the matching ack is high.
REQ-012 SHALL have ports m0_data_out / m1_data_out  out  4*DATA_WIDTH  read data, valid only while the matching ack is high.
REQ-013 SHALL have ports rs_req  out  2, rs_wnr  out  1, rs_address  out  ADDR_WIDTH, rs_data_in  out  4*DATA_WIDTH, forming the register-set command.
REQ-014 SHALL have ports rs_ack  in  1 and rs_data_out  in  4*DATA_WIDTH, the register-set response.
REQ-015 SHALL have ports busy  out  1 (state != IDLE) and owner  out  1 (index of the granted requester).

Function
REQ-016 SHALL implement a FSM with states IDLE, ISSUE, WAIT and RESP, all outputs registered.
REQ-017 IDLE: if any mN_req != 0, SHALL grant one requester, latch its req/wnr/address/data, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 SHALL arbitrate round-robin: if both requesters are pending, grant the one not granted last; last_grant resets to 1, so m0 wins the first tie.
REQ-019 SHALL check the range at grant: bytes = 1/2/4 for req 1/2/3; if address + bytes - 1 > 2^ADDR_WIDTH - 1 (wrap), SHALL skip ISSUE and WAIT, go directly to RESP with err = 1, and perform no register-set access.
REQ-020 ISSUE: SHALL drive rs_req = latched req for exactly one cycle, then go to WAIT.
REQ-021 SHALL hold rs_wnr, rs_address and rs_data_in stable from ISSUE through WAIT.
REQ-022 SHALL drive rs_data_in to 0 on reads.
REQ-023 SHALL drive rs_req to 0 in every state except ISSUE.
REQ-024 WAIT: on rs_ack = 1, SHALL capture rs_data_out (reads only; writes capture 0) and go to RESP with err = 0.
REQ-025 WAIT: SHALL count with an 8-bit counter cleared on entry to WAIT; if TIMEOUT cycles pass without rs_ack, SHALL go to RESP with err = 1 and data = 0.
REQ-026 RESP: SHALL assert the granted mN_ack = 1 for one cycle, with mN_err and mN_data_out, then return to IDLE.
REQ-027 Outside RESP, SHALL hold every ack, err and data_out at 0; the non-granted requester's outputs SHALL stay at 0.
REQ-028 Latency: a request sampled in IDLE at cycle 0 SHALL give rs_req in cycle 1, accept rs_ack in cycle 2, and give mN_ack in cycle 3 (range error: mN_ack in cycle 1).
REQ-029 Requester protocol: mN_req and its fields stay stable until ack, and mN_req is 0 in the cycle after ack. The arbiter SHALL accept at most one transaction per requester per ack.
REQ-030 SHALL ignore rs_ack in IDLE, ISSUE or RESP (late ack after timeout), with no state change.
REQ-031 SHALL ignore a requester dropping req mid-transaction; the transaction SHALL still complete and ack.

Reset
REQ-032 While reset is high, asynchronously: state = IDLE, last_grant = 1, counter = 0, every output = 0 (busy = 0, owner = 0).
REQ-033 Reset mid-transaction SHALL drop the transaction with no ack; after reset deasserts, the first rising edge SHALL sample the requests afresh.

Verification
REQ-034 Single read: m0 req=3, wnr=0, address=0x10; model returns rs_ack with 0xDDCCBBAA -> rs_req=3 in cycle 1; m0_ack=1, m0_err=0, m0_data_out=0xDDCCBBAA in cycle 3.
REQ-035 Tie: m0 and m1 both request from reset, each re-requesting immediately -> grants m0, m1, m0, m1; owner toggles; no cycle has both acks high.
REQ-036 Range error: m1 req=3, address=0xFE -> m1_ack=1, m1_err=1 in cycle 1; rs_req stays 0 throughout.
REQ-037 Timeout: model never acks -> with TIMEOUT=15, m0_err=1 and m0_ack=1 sixteen cycles after ISSUE; an rs_ack injected afterwards is ignored.
REQ-038 Reset in WAIT: assert reset while busy=1 -> all outputs 0 immediately; no ack after release; the next request completes normally.
REQ-039 Write 2 bytes: m1 req=2, wnr=1, address=0x20, data=0x0000BEEF -> rs_address=0x20, rs_data_in=0x0000BEEF; m1_ack with m1_data_out=0.
